// File: rtl/axi4_lite_slave_mem.sv
// AXI4-Lite slave backed by a word-addressed on-chip memory.
// After reset an init sweep clears every word, one per cycle, before any
// AXI access is accepted; mem_init_done reports completion.
// Write channel: AW and W are accepted in any order, one write outstanding.
// Read channel: one-cycle registered read, response held until RREADY.
// Optional build macro AXIL_SLV_ADDR_CHECK_EN: addresses with bits set above
// the memory range get SLVERR (writes dropped, reads return zero); without it
// upper address bits are ignored and the memory aliases.
module axi4_lite_slave_mem #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 32,
  parameter int MEM_DEPTH_LOG2     = 8
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic                            mem_init_done
);

  localparam int DEPTH  = 2 ** MEM_DEPTH_LOG2;
  localparam int NBYTES = C_S_AXI_DATA_WIDTH / 8;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {W_IDLE, W_RESP} wstate_t;
  typedef enum logic {R_IDLE, R_DATA} rstate_t;

  logic [C_S_AXI_DATA_WIDTH-1:0] mem [DEPTH];

  logic [MEM_DEPTH_LOG2-1:0]     init_cnt;
  logic                          init_done;

  wstate_t                       wstate, wstate_nxt;
  logic                          aw_latched, w_latched;
  logic [C_S_AXI_ADDR_WIDTH-1:0] awaddr_q;
  logic [C_S_AXI_DATA_WIDTH-1:0] wdata_q;
  logic [NBYTES-1:0]             wstrb_q;
  logic [1:0]                    bresp_q;
  logic                          aw_hs, w_hs, wr_commit;
  logic [C_S_AXI_ADDR_WIDTH-1:0] wr_addr;
  logic [C_S_AXI_DATA_WIDTH-1:0] wr_data;
  logic [NBYTES-1:0]             wr_strb;
  logic [MEM_DEPTH_LOG2-1:0]     wr_idx;
  logic                          wr_addr_ok;

  rstate_t                       rstate, rstate_nxt;
  logic                          ar_hs;
  logic [MEM_DEPTH_LOG2-1:0]     rd_idx;
  logic                          rd_addr_ok;
  logic [C_S_AXI_DATA_WIDTH-1:0] rdata_p1;
  logic [1:0]                    rresp_p1;

  logic                          unused_ok;

  // Channel handshakes; readies depend only on registered state
  assign S_AXI_AWREADY = init_done && (wstate == W_IDLE) && !aw_latched;
  assign S_AXI_WREADY  = init_done && (wstate == W_IDLE) && !w_latched;
  assign S_AXI_ARREADY = init_done && (rstate == R_IDLE);
  assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs  = S_AXI_WVALID && S_AXI_WREADY;
  assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;

  // A beat handshaken this cycle bypasses its holding register
  assign wr_addr = aw_latched ? awaddr_q : S_AXI_AWADDR;
  assign wr_data = w_latched ? wdata_q : S_AXI_WDATA;
  assign wr_strb = w_latched ? wstrb_q : S_AXI_WSTRB;
  assign wr_idx  = wr_addr[MEM_DEPTH_LOG2+1:2];
  assign rd_idx  = S_AXI_ARADDR[MEM_DEPTH_LOG2+1:2];

`ifdef AXIL_SLV_ADDR_CHECK_EN
  assign wr_addr_ok = (wr_addr >> (MEM_DEPTH_LOG2 + 2)) == '0;
  assign rd_addr_ok = (S_AXI_ARADDR >> (MEM_DEPTH_LOG2 + 2)) == '0;
`else
  assign wr_addr_ok = 1'b1;
  assign rd_addr_ok = 1'b1;
`endif

  // Protection bits and out-of-range address bits carry no meaning here
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, wr_addr, S_AXI_ARADDR};

  assign S_AXI_BVALID  = (wstate == W_RESP);
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_RVALID  = (rstate == R_DATA);
  assign S_AXI_RDATA   = rdata_p1;
  assign S_AXI_RRESP   = rresp_p1;
  assign mem_init_done = init_done;

  // Init sweep: clear one word per cycle after reset, then flag completion
  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      init_cnt  <= '0;
      init_done <= 1'b0;
    end else if (!init_done) begin
      init_cnt <= init_cnt + 1'b1;
      if (init_cnt == '1) init_done <= 1'b1;
    end
  end

  // Memory array: sweep clears, committed writes merge by byte strobe
  always_ff @(posedge S_AXI_ACLK) begin
    if (!init_done) begin
      mem[init_cnt] <= '0;
    end else if (wr_commit && wr_addr_ok) begin
      for (int b = 0; b < NBYTES; b++) begin
        if (wr_strb[b]) mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  // Write FSM state register
  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) wstate <= W_IDLE;
    else              wstate <= wstate_nxt;
  end

  // Write FSM next state: commit once both address and data are in hand
  always_comb begin
    wstate_nxt = wstate;
    wr_commit  = 1'b0;
    case (wstate)
      W_IDLE: begin
        if ((aw_latched || aw_hs) && (w_latched || w_hs)) begin
          wr_commit  = 1'b1;
          wstate_nxt = W_RESP;
        end
      end
      W_RESP: begin
        if (S_AXI_BREADY) wstate_nxt = W_IDLE;
      end
      default: wstate_nxt = W_IDLE;
    endcase
  end

  // Write control: beat-latched flags and the response code
  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      aw_latched <= 1'b0;
      w_latched  <= 1'b0;
      bresp_q    <= RESP_OKAY;
    end else if (wr_commit) begin
      aw_latched <= 1'b0;
      w_latched  <= 1'b0;
      bresp_q    <= wr_addr_ok ? RESP_OKAY : RESP_SLVERR;
    end else begin
      if (aw_hs) aw_latched <= 1'b1;
      if (w_hs)  w_latched  <= 1'b1;
    end
  end

  // Write beat holding registers for the case where AW and W arrive apart
  always_ff @(posedge S_AXI_ACLK) begin
    if (aw_hs) awaddr_q <= S_AXI_AWADDR;
    if (w_hs) begin
      wdata_q <= S_AXI_WDATA;
      wstrb_q <= S_AXI_WSTRB;
    end
  end

  // Read FSM state register
  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) rstate <= R_IDLE;
    else              rstate <= rstate_nxt;
  end

  // Read FSM next state: hold the response until the master takes it
  always_comb begin
    rstate_nxt = rstate;
    case (rstate)
      R_IDLE:  if (ar_hs) rstate_nxt = R_DATA;
      R_DATA:  if (S_AXI_RREADY) rstate_nxt = R_IDLE;
      default: rstate_nxt = R_IDLE;
    endcase
  end

  // ---- read stage p1: data captured on the AR handshake (sees pre-write contents)
  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      rdata_p1 <= '0;
      rresp_p1 <= RESP_OKAY;
    end else if (ar_hs) begin
      rdata_p1 <= rd_addr_ok ? mem[rd_idx] : '0;
      rresp_p1 <= rd_addr_ok ? RESP_OKAY : RESP_SLVERR;
    end
  end

endmodule

// File: tb/tb_axi4_lite_slave_mem.sv
// Directed bench for axi4_lite_slave_mem with a response scoreboard.
module tb_axi4_lite_slave_mem;

  logic        clk;
  logic        rst;
  logic [31:0] awaddr;
  logic [2:0]  awprot;
  logic        awvalid, awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid, wready;
  logic [1:0]  bresp;
  logic        bvalid, bready;
  logic [31:0] araddr;
  logic [2:0]  arprot;
  logic        arvalid, arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid, rready;
  logic        init_done;

  int tests = 0;
  int fails = 0;

  logic [1:0]  bq[$];
  logic [31:0] rdq[$];
  logic [1:0]  rrq[$];

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  axi4_lite_slave_mem dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESET  (rst),
    .S_AXI_AWADDR  (awaddr),
    .S_AXI_AWPROT  (awprot),
    .S_AXI_AWVALID (awvalid),
    .S_AXI_AWREADY (awready),
    .S_AXI_WDATA   (wdata),
    .S_AXI_WSTRB   (wstrb),
    .S_AXI_WVALID  (wvalid),
    .S_AXI_WREADY  (wready),
    .S_AXI_BRESP   (bresp),
    .S_AXI_BVALID  (bvalid),
    .S_AXI_BREADY  (bready),
    .S_AXI_ARADDR  (araddr),
    .S_AXI_ARPROT  (arprot),
    .S_AXI_ARVALID (arvalid),
    .S_AXI_ARREADY (arready),
    .S_AXI_RDATA   (rdata),
    .S_AXI_RRESP   (rresp),
    .S_AXI_RVALID  (rvalid),
    .S_AXI_RREADY  (rready),
    .mem_init_done (init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reset held for a few cycles, released mid-cycle, then the sweep is timed
  task automatic reset_and_init();
    int n;
    rst = 1'b1;
    awvalid = 0; wvalid = 0; arvalid = 0; bready = 0; rready = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    while (!init_done && n < 400) begin
      step();
      n++;
      if (n == 128) begin
        check("ready_during_init", {29'd0, awready, wready, arready}, 32'd0);
      end
    end
    check("init_cycles", n, 256);
    check("init_done_high", init_done, 1);
  endtask

  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int aw_start, input int w_start, input logic [1:0] er);
    bit aw_done = 0;
    bit w_done = 0;
    int c = 0;
    bq.push_back(er);
    awaddr = a; wdata = d; wstrb = s;
    while (!(aw_done && w_done) && c < 60) begin
      awvalid = !aw_done && (c >= aw_start);
      wvalid  = !w_done && (c >= w_start);
      if (aw_done) check("awready_drop", awready, 0);
      if (w_done)  check("wready_drop", wready, 0);
      if (awvalid && awready) aw_done = 1;
      if (wvalid && wready)   w_done = 1;
      step();
      c++;
    end
    awvalid = 0; wvalid = 0;
    check("write_accepted", {31'd0, aw_done && w_done}, 1);
  endtask

  task automatic b_resp(input int hold);
    int c = 0;
    logic [1:0] er;
    while (!bvalid && c < 20) begin step(); c++; end
    check("bvalid_seen", bvalid, 1);
    er = (bq.size() > 0) ? bq.pop_front() : 2'bxx;
    check("bresp", bresp, er);
    for (int i = 0; i < hold; i++) begin
      step();
      check("bvalid_hold", bvalid, 1);
      check("bresp_hold", bresp, er);
      check("awready_in_resp", awready, 0);
    end
    bready = 1;
    step();
    bready = 0;
    check("bvalid_single", bvalid, 0);
    check("awready_after_b", awready, 1);
  endtask

  task automatic axi_read(input logic [31:0] a, input logic [31:0] ed, input logic [1:0] er,
                          input int hold);
    int c = 0;
    logic [31:0] xd;
    logic [1:0]  xr;
    rdq.push_back(ed);
    rrq.push_back(er);
    araddr = a;
    arvalid = 1;
    while (!arready && c < 40) begin step(); c++; end
    check("arready_seen", arready, 1);
    step();
    arvalid = 0;
    check("rvalid_latency", rvalid, 1);
    xd = (rdq.size() > 0) ? rdq.pop_front() : 32'hxxxxxxxx;
    xr = (rrq.size() > 0) ? rrq.pop_front() : 2'bxx;
    check("rdata", rdata, xd);
    check("rresp", rresp, xr);
    for (int i = 0; i < hold; i++) begin
      step();
      check("rvalid_hold", rvalid, 1);
      check("rdata_hold", rdata, xd);
      check("arready_in_data", arready, 0);
    end
    rready = 1;
    step();
    rready = 0;
    check("rvalid_drop", rvalid, 0);
    check("arready_after_r", arready, 1);
  endtask

  initial begin
    rst = 1'b1;
    awaddr = 0; awprot = 0; awvalid = 0; wdata = 0; wstrb = 0; wvalid = 0;
    bready = 0; araddr = 0; arprot = 0; arvalid = 0; rready = 0;
    #12;
    check("rst_readies", {29'd0, awready, wready, arready}, 32'd0);
    check("rst_valids", {30'd0, bvalid, rvalid}, 32'd0);
    check("rst_resps", {28'd0, bresp, rresp}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_init_done", init_done, 0);

    reset_and_init();
    axi_read(32'h10, 32'h0, OKAY, 0);

    // AW leads W by three cycles
    axi_write(32'h04, 32'hDEADBEEF, 4'b1111, 0, 3, OKAY);
    b_resp(0);
    axi_read(32'h04, 32'hDEADBEEF, OKAY, 0);

    // W leads AW, then a partial-strobe write with both beats together
    axi_write(32'h08, 32'h11223344, 4'b1111, 2, 0, OKAY);
    b_resp(0);
    axi_write(32'h08, 32'hAABBCCDD, 4'b0101, 0, 0, OKAY);
    b_resp(0);
    axi_read(32'h08, 32'h11BB33DD, OKAY, 0);

    // Empty strobe still responds and leaves memory alone; low address bits ignored
    axi_write(32'h04, 32'h01234567, 4'b0000, 0, 0, OKAY);
    b_resp(0);
    axi_read(32'h07, 32'hDEADBEEF, OKAY, 0);

    // Backpressure on both response channels
    axi_write(32'h14, 32'h0BADF00D, 4'b1111, 0, 0, OKAY);
    b_resp(5);
    axi_read(32'h14, 32'h0BADF00D, OKAY, 5);

    // Read and write to the same word on the same edge
    awaddr = 32'h0C; wdata = 32'hCAFEF00D; wstrb = 4'b1111; araddr = 32'h0C;
    awvalid = 1; wvalid = 1; arvalid = 1;
    check("same_edge_readies", {29'd0, awready, wready, arready}, 32'd7);
    step();
    awvalid = 0; wvalid = 0; arvalid = 0;
    check("same_edge_valids", {30'd0, bvalid, rvalid}, 32'd3);
    check("same_edge_old_data", rdata, 32'h0);
    bready = 1; rready = 1;
    step();
    bready = 0; rready = 0;
    check("same_edge_done", {30'd0, bvalid, rvalid}, 32'd0);
    axi_read(32'h0C, 32'hCAFEF00D, OKAY, 0);

    // Out-of-range address
`ifdef AXIL_SLV_ADDR_CHECK_EN
    axi_write(32'h400, 32'h5, 4'b1111, 0, 0, SLVERR);
    b_resp(0);
    axi_read(32'h000, 32'h0, OKAY, 0);
    axi_read(32'h400, 32'h0, SLVERR, 0);
    axi_read(32'h404, 32'h0, SLVERR, 0);
`else
    axi_write(32'h400, 32'h5, 4'b1111, 0, 0, OKAY);
    b_resp(0);
    axi_read(32'h000, 32'h5, OKAY, 0);
    axi_read(32'h404, 32'hDEADBEEF, OKAY, 0);
`endif

    // Reset while a write response is pending
    axi_write(32'h20, 32'h12345678, 4'b1111, 0, 0, OKAY);
    check("bvalid_before_rst", bvalid, 1);
    void'(bq.pop_front());
    rst = 1'b1;
    #1;
    check("bvalid_in_rst", bvalid, 0);
    check("init_done_in_rst", init_done, 0);
    check("readies_in_rst", {29'd0, awready, wready, arready}, 32'd0);
    reset_and_init();
    axi_read(32'h20, 32'h0, OKAY, 0);
    axi_read(32'h04, 32'h0, OKAY, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/axi4_lite_slave_mem.md
AXI4_LITE_SLAVE_MEM -- requirements
Module: AXI4_Lite_Slave_Mem

Interface
REQ-001 The block SHALL have one clock, and its reset SHALL be asynchronous and active-high.
REQ-002 Parameter C_S_AXI_DATA_WIDTH, default 32, SHALL set the data bus width; only 32 is supported.
REQ-003 Parameter C_S_AXI_ADDR_WIDTH, default 32, SHALL set the byte address width.
REQ-004 Parameter MEM_DEPTH_LOG2, default 8, SHALL set the word memory depth to 2**MEM_DEPTH_LOG2.
REQ-005 The ports SHALL be as follows (name, direction, width, meaning):
- S_AXI_ACLK, in, 1, clock.
- S_AXI_ARESET, in, 1, asynchronous active-high reset.
- S_AXI_AWADDR, in, ADDR, write address.
- S_AXI_AWPROT, in, 3, ignored.
- S_AXI_AWVALID, in, 1; S_AXI_AWREADY, out, 1: write address handshake.
- S_AXI_WDATA, in, 32, write data.
- S_AXI_WSTRB, in, 4, byte enables.
- S_AXI_WVALID, in, 1; S_AXI_WREADY, out, 1: write data handshake.
- S_AXI_BRESP, out, 2; S_AXI_BVALID, out, 1; S_AXI_BREADY, in, 1: write response.
- S_AXI_ARADDR, in, ADDR, read address.
- S_AXI_ARPROT, in, 3, ignored.
- S_AXI_ARVALID, in, 1; S_AXI_ARREADY, out, 1: read address handshake.
- S_AXI_RDATA, out, 32; S_AXI_RRESP, out, 2; S_AXI_RVALID, out, 1; S_AXI_RREADY, in, 1: read data.
- mem_init_done, out, 1: high once the clear sweep completes; drives the CPU's mem_busya/mem_busyb input.

Function
REQ-006 Word index SHALL be ADDR[MEM_DEPTH_LOG2+1:2]; ADDR[1:0] SHALL be ignored.
REQ-007 After reset, an init counter SHALL write zero to every word, one word per cycle, then assert mem_init_done.
- mem_init_done high 2**MEM_DEPTH_LOG2 cycles after reset release, and stays high.
- AWREADY, WREADY and ARREADY SHALL be low until mem_init_done is high.
REQ-008 The write FSM SHALL use states W_IDLE and W_RESP, and AW and W SHALL be accepted in either order or together.
- In W_IDLE, AWREADY is high while no address is latched; WREADY is high while no data is latched.
- Each ready SHALL drop the cycle after its handshake.
- When both address and data are latched, the memory write SHALL occur on that edge and the FSM SHALL enter W_RESP.
REQ-009 In W_RESP, BVALID SHALL be high and held with BRESP stable until BREADY; on the handshake the FSM SHALL return to W_IDLE.
- Only one write SHALL be outstanding at a time.
REQ-010 The write SHALL update byte lane i only where WSTRB[i]=1; WSTRB=0000 SHALL write nothing and still respond.
REQ-011 The read FSM SHALL use states R_IDLE and R_DATA.
- ARREADY is high in R_IDLE.
- On the AR handshake, RDATA is registered from memory and RVALID rises the next cycle (1-cycle latency).
REQ-012 In R_DATA, RVALID, RDATA and RRESP SHALL be held until RREADY; on the handshake the FSM SHALL return to R_IDLE.
REQ-013 The read and write channels SHALL be independent and may complete in the same cycle.
- A read handshaken on the same edge as a write commit to the same word SHALL return the pre-write data.
REQ-014 VALID outputs SHALL never depend combinationally on READY inputs.

Reset
REQ-015 On S_AXI_ARESET, the following SHALL clear immediately, including mid-transaction; pending transactions are dropped without response:
- all READY/VALID outputs to 0
- BRESP, RRESP, RDATA to 0
- mem_init_done to 0
- both FSMs to IDLE
- latched AW/W flags cleared
- init counter to 0
REQ-016 After release, memory contents SHALL be zero before any access is accepted (per REQ-007).

Configuration
REQ-017 With AXIL_SLV_ADDR_CHECK_EN defined:
- An address with any bit above MEM_DEPTH_LOG2+1 set SHALL return SLVERR (2'b10).
- A write to such an address SHALL NOT modify memory.
- A read from such an address SHALL return RDATA 0.
REQ-018 Without AXIL_SLV_ADDR_CHECK_EN, upper address bits SHALL be ignored: addresses alias modulo the depth and the response is always OKAY (2'b00).

Verification
REQ-019 Reset, then idle: mem_init_done rises exactly 256 cycles after release; a read of 0x10 returns 0x00000000, OKAY.
REQ-020 AW 0x04 presented 3 cycles before W 0xDEADBEEF with strobe 1111 -> one BVALID with OKAY; a read of 0x04 then returns 0xDEADBEEF.
REQ-021 Write 0x11223344 to 0x08, then W 0xAABBCCDD with WSTRB 0101 to 0x08 -> a read of 0x08 returns 0x11BB33DD.
REQ-022 BREADY and RREADY held low for 5 cycles -> BVALID, RVALID, RDATA and BRESP stay stable; next AWREADY/ARREADY only after the respective handshake.
REQ-023 With AXIL_SLV_ADDR_CHECK_EN, write 0x5 to 0x400 -> BRESP SLVERR, word 0 unchanged. Without the macro -> OKAY and word 0 becomes 0x5.
REQ-024 Reset asserted while BVALID is high -> BVALID is 0 in the same cycle; the sweep reruns and a read of the previously written address returns 0.
